// File: rtl/dmem_lsu_ctrl.sv
// Load/store sequencer between an RV32I core and a word-only synchronous data memory.
// Handles sub-word load extension, read-modify-write sub-word stores and access checks.
`timescale 1ns/1ps

module dmem_lsu_ctrl #(
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,
    parameter int unsigned MEM_BYTES  = 1 << 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rw,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LD_RD  = 3'd1;
    localparam logic [2:0] S_LD_CAP = 3'd2;
    localparam logic [2:0] S_ST_WR  = 3'd3;
    localparam logic [2:0] S_RMW_RD = 3'd4;
    localparam logic [2:0] S_RMW_WR = 3'd5;
    localparam logic [2:0] S_RESP   = 3'd6;

    logic [2:0]            state;
    logic [2:0]            funct3_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  req_bad;
    logic [DATA_WIDTH-1:0] load_ext;
    logic [DATA_WIDTH-1:0] merged;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        req_bad = 1'b0;
        case (req_funct3)
            3'b000:  req_bad = 1'b0;
            3'b100:  req_bad = req_we;
            3'b001:  req_bad = req_addr[0];
            3'b101:  req_bad = req_we | req_addr[0];
            3'b010:  req_bad = |req_addr[1:0];
            default: req_bad = 1'b1;
        endcase
        if (req_addr >= ADDR_WIDTH'(MEM_BYTES))
            req_bad = 1'b1;
    end

    assign ld_byte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    assign ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        load_ext = mem_rdata;
        case (funct3_q)
            3'b000:  load_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  load_ext = {24'h0, ld_byte};
            3'b001:  load_ext = {{16{ld_half[15]}}, ld_half};
            3'b101:  load_ext = {16'h0, ld_half};
            default: load_ext = mem_rdata;
        endcase
    end

    // Sub-word store: replace only the target lane of the word read back in RMW_RD.
    always_comb begin
        merged = mem_rdata;
        if (funct3_q[0])
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        else
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end

    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_RESP);
    assign mem_addr   = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign mem_rw     = (state == S_ST_WR) || (state == S_RMW_WR);
    assign mem_wdata  = (state == S_ST_WR)  ? wdata_q :
                        (state == S_RMW_WR) ? merged  : '0;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            funct3_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        funct3_q   <= req_funct3;
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata;
                        resp_rdata <= '0;
                        resp_err   <= req_bad;
                        if (req_bad)
                            state <= S_RESP;
                        else if (!req_we)
                            state <= S_LD_RD;
                        else if (req_funct3 == 3'b010)
                            state <= S_ST_WR;
                        else
                            state <= S_RMW_RD;
                    end
                end
                S_LD_RD:  state <= S_LD_CAP;
                S_LD_CAP: begin
                    resp_rdata <= load_ext;
                    state      <= S_RESP;
                end
                S_ST_WR:  state <= S_RESP;
                S_RMW_RD: state <= S_RMW_WR;
                S_RMW_WR: state <= S_RESP;
                S_RESP: begin
                    if (resp_ready)
                        state <= S_IDLE;
                end
                default:  state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Directed bench for dmem_lsu_ctrl with a small synchronous word memory model.
// Expected values are hand-computed from the load/store semantics.
`timescale 1ns/1ps

module tb_dmem_lsu_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic        mem_rw;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:1023];
    int          wr_cnt;
    int          total;
    int          bad;

    dmem_lsu_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_rw     (mem_rw),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rw)
            mem[mem_addr[11:2]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[11:2]];
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wr_cnt <= wr_cnt;
        else if (mem_rw)
            wr_cnt <= wr_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int exp_lat, input logic [31:0] exp_rdata,
                          input logic exp_err, input int exp_wr);
        int lat;
        int w0;
        @(negedge clk);
        check({tag, ":ready"}, {31'b0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        w0         = wr_cnt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid && lat < 20);
        check({tag, ":lat"},   32'(lat), 32'(exp_lat));
        check({tag, ":rdata"}, resp_rdata, exp_rdata);
        check({tag, ":err"},   {31'b0, resp_err}, {31'b0, exp_err});
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        check({tag, ":writes"}, 32'(wr_cnt - w0), 32'(exp_wr));
    endtask

    initial begin
        int w0;
        int lat;
        total      = 0;
        bad        = 0;
        wr_cnt     = 0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst:resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst:resp_rdata", resp_rdata, 32'd0);
        check("rst:resp_err",   {31'b0, resp_err}, 32'd0);
        check("rst:mem_rw",     {31'b0, mem_rw}, 32'd0);
        check("rst:mem_addr",   mem_addr, 32'd0);
        check("rst:mem_wdata",  mem_wdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst:req_ready",  {31'b0, req_ready}, 32'd1);

        // Word store and load-back
        do_req("sw100", 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 2, 32'h0, 1'b0, 1);
        check("sw100:mem", mem[10'h40], 32'hDEADBEEF);
        do_req("lw100", 1'b0, 3'b010, 32'h100, 32'h0, 3, 32'hDEADBEEF, 1'b0, 0);

        // Byte store via read-modify-write, then signed/unsigned byte loads
        do_req("sb101", 1'b1, 3'b000, 32'h101, 32'h1234567F, 3, 32'h0, 1'b0, 1);
        check("sb101:mem", mem[10'h40], 32'hDEAD7FEF);
        do_req("lb103",  1'b0, 3'b000, 32'h103, 32'h0, 3, 32'hFFFFFFDE, 1'b0, 0);
        do_req("lbu103", 1'b0, 3'b100, 32'h103, 32'h0, 3, 32'h000000DE, 1'b0, 0);
        do_req("lb101",  1'b0, 3'b000, 32'h101, 32'h0, 3, 32'h0000007F, 1'b0, 0);

        // Half store, then signed/unsigned half loads
        do_req("sh102", 1'b1, 3'b001, 32'h102, 32'hABCD8001, 3, 32'h0, 1'b0, 1);
        check("sh102:mem", mem[10'h40], 32'h80017FEF);
        do_req("lh102",  1'b0, 3'b001, 32'h102, 32'h0, 3, 32'hFFFF8001, 1'b0, 0);
        do_req("lhu102", 1'b0, 3'b101, 32'h102, 32'h0, 3, 32'h00008001, 1'b0, 0);
        do_req("lh100",  1'b0, 3'b001, 32'h100, 32'h0, 3, 32'h00007FEF, 1'b0, 0);

        // Error cases: one-cycle response, no memory write, zero data
        do_req("lw102",  1'b0, 3'b010, 32'h102,    32'h0, 1, 32'h0, 1'b1, 0);
        do_req("lh101",  1'b0, 3'b001, 32'h101,    32'h0, 1, 32'h0, 1'b1, 0);
        do_req("sw_oor", 1'b1, 3'b010, 32'h1FFFFC, 32'h55555555, 1, 32'h0, 1'b1, 0);
        do_req("sbu",    1'b1, 3'b100, 32'h100,    32'h0, 1, 32'h0, 1'b1, 0);
        do_req("f3_011", 1'b0, 3'b011, 32'h100,    32'h0, 1, 32'h0, 1'b1, 0);
        check("err:mem", mem[10'h40], 32'h80017FEF);

        // Back-pressure: response held, competing request ignored
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100;
        w0 = wr_cnt;
        @(posedge clk);
        #1 req_we = 1'b1; req_wdata = 32'h0; req_addr = 32'h100;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid && lat < 20);
        check("hold:lat", 32'(lat), 32'd3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold:valid", {31'b0, resp_valid}, 32'd1);
            check("hold:rdata", resp_rdata, 32'h80017FEF);
            check("hold:ready", {31'b0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        req_valid  = 1'b0;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        check("hold:idle",   {31'b0, resp_valid}, 32'd0);
        check("hold:writes", 32'(wr_cnt - w0), 32'd0);
        check("hold:mem",    mem[10'h40], 32'h80017FEF);

        // Reset during RMW_RD of a byte store
        do_req("sw200", 1'b1, 3'b010, 32'h200, 32'h11223344, 2, 32'h0, 1'b0, 1);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
        req_addr  = 32'h200; req_wdata = 32'h000000AA;
        w0 = wr_cnt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rstmid:mem_rw",     {31'b0, mem_rw}, 32'd0);
        check("rstmid:resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rstmid:mem_addr",   mem_addr, 32'd0);
        check("rstmid:req_ready",  {31'b0, req_ready}, 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rstmid:writes", 32'(wr_cnt - w0), 32'd0);
        check("rstmid:mem",    mem[10'h80], 32'h11223344);
        do_req("lw200", 1'b0, 3'b010, 32'h200, 32'h0, 3, 32'h11223344, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
